// File: rtl/morse_pkg.sv
// Shared Morse receiver definitions: character codes, FSM states and
// symbol-register sizing.
package morse_pkg;

  // Character codes: A-Z = 0..25, 0-9 = 26..35
  localparam logic [5:0] CODE_A       = 6'd0;
  localparam logic [5:0] CODE_0       = 6'd26;
  localparam logic [5:0] CODE_SPACE   = 6'd36;
  localparam logic [5:0] CODE_UNKNOWN = 6'd63;

  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESS, GAP} state_t;

  // Width of the symbol-count field, able to hold 0..max_syms
  function automatic int len_w(input int max_syms);
    return $clog2(max_syms + 1);
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse decoder. Pattern bit 0 is the first symbol, dash = 1.
// Anything that is not a standard letter or digit decodes to CODE_UNKNOWN.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = 5
) (
  input  logic [len_w(MAX_SYMS)-1:0] len,
  input  logic [MAX_SYMS-1:0]        pattern,
  output logic [5:0]                 code
);

  int         l;
  logic [4:0] pat5;
  logic [7:0] key;

  // Look up {length, first five symbols}; bits past the length are masked
  always_comb begin
    l = int'(len);
    for (int i = 0; i < 5; i++)
      pat5[i] = (i < MAX_SYMS && i < l) ? pattern[i] : 1'b0;
    key  = {3'(l), pat5};
    code = CODE_UNKNOWN;
    if (l <= 5) begin
      case (key)
        {3'd2, 5'b00010}: code = 6'd0;   // A .-
        {3'd4, 5'b00001}: code = 6'd1;   // B -...
        {3'd4, 5'b00101}: code = 6'd2;   // C -.-.
        {3'd3, 5'b00001}: code = 6'd3;   // D -..
        {3'd1, 5'b00000}: code = 6'd4;   // E .
        {3'd4, 5'b00100}: code = 6'd5;   // F ..-.
        {3'd3, 5'b00011}: code = 6'd6;   // G --.
        {3'd4, 5'b00000}: code = 6'd7;   // H ....
        {3'd2, 5'b00000}: code = 6'd8;   // I ..
        {3'd4, 5'b01110}: code = 6'd9;   // J .---
        {3'd3, 5'b00101}: code = 6'd10;  // K -.-
        {3'd4, 5'b00010}: code = 6'd11;  // L .-..
        {3'd2, 5'b00011}: code = 6'd12;  // M --
        {3'd2, 5'b00001}: code = 6'd13;  // N -.
        {3'd3, 5'b00111}: code = 6'd14;  // O ---
        {3'd4, 5'b00110}: code = 6'd15;  // P .--.
        {3'd4, 5'b01011}: code = 6'd16;  // Q --.-
        {3'd3, 5'b00010}: code = 6'd17;  // R .-.
        {3'd3, 5'b00000}: code = 6'd18;  // S ...
        {3'd1, 5'b00001}: code = 6'd19;  // T -
        {3'd3, 5'b00100}: code = 6'd20;  // U ..-
        {3'd4, 5'b01000}: code = 6'd21;  // V ...-
        {3'd3, 5'b00110}: code = 6'd22;  // W .--
        {3'd4, 5'b01001}: code = 6'd23;  // X -..-
        {3'd4, 5'b01101}: code = 6'd24;  // Y -.--
        {3'd4, 5'b00011}: code = 6'd25;  // Z --..
        {3'd5, 5'b11111}: code = 6'd26;  // 0 -----
        {3'd5, 5'b11110}: code = 6'd27;  // 1 .----
        {3'd5, 5'b11100}: code = 6'd28;  // 2 ..---
        {3'd5, 5'b11000}: code = 6'd29;  // 3 ...--
        {3'd5, 5'b10000}: code = 6'd30;  // 4 ....-
        {3'd5, 5'b00000}: code = 6'd31;  // 5 .....
        {3'd5, 5'b00001}: code = 6'd32;  // 6 -....
        {3'd5, 5'b00011}: code = 6'd33;  // 7 --...
        {3'd5, 5'b00111}: code = 6'd34;  // 8 ---..
        {3'd5, 5'b01111}: code = 6'd35;  // 9 ----.
        default:          code = CODE_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/morse_rx.sv
// Morse key receiver: synchroniser + debouncer, press/gap timing FSM,
// symbol assembly, LUT decode and an output character FIFO.
module morse_rx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DASH_UNITS      = 2,
  parameter int CHAR_GAP_UNITS  = 2,
  parameter int WORD_GAP_UNITS  = 5,
  parameter int MAX_SYMS        = 5,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          button,
  output logic [5:0]                    char_code,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic                          dot_out,
  output logic                          dash_out,
  output logic                          interchar_out,
  output logic                          interword_out,
  output logic [3:0]                    t,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(UNIT_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = len_w(MAX_SYMS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DASH_T = 4'(DASH_UNITS);
  localparam logic [3:0] CHAR_T = 4'(CHAR_GAP_UNITS);
  localparam logic [3:0] WORD_T = 4'(WORD_GAP_UNITS);

  // ---------------- input path ----------------
  logic          sync1, sync2, deb;
  logic [DW-1:0] db_cnt;

  // Synchronise and debounce. The path resets to "pressed" so LOCKOUT only
  // exits after a genuinely debounced key-up, even if the key was held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      deb    <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic          t_new;         // t advanced on the previous edge
  logic          push;
  logic [5:0]    push_code, sym_code, lut_code;
  logic          sym_bad;
  logic [LW-1:0] sym_len;
  logic [MAX_SYMS-1:0] sym_pat;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= LOCKOUT;
    else        state <= state_next;
  end

  // Next state, classification / gap pulses and FIFO push request
  always_comb begin
    state_next    = state;
    dot_out       = 1'b0;
    dash_out      = 1'b0;
    interchar_out = 1'b0;
    interword_out = 1'b0;
    push          = 1'b0;
    push_code     = sym_code;
    case (state)
      LOCKOUT: if (!deb) state_next = IDLE;
      IDLE:    if (deb)  state_next = PRESS;
      PRESS: begin
        if (!deb) begin
          state_next = GAP;
          if (t >= DASH_T) dash_out = 1'b1;
          else             dot_out  = 1'b1;
        end
      end
      GAP: begin
        if (t_new && t == CHAR_T) begin
          interchar_out = 1'b1;
          push          = 1'b1;
        end else if (t_new && t == WORD_T) begin
          interword_out = 1'b1;
          push          = 1'b1;
          push_code     = CODE_SPACE;
          state_next    = IDLE;
        end
        if (deb) state_next = PRESS;
      end
      default: state_next = LOCKOUT;
    endcase
  end

  // Unit timer: restarts on every state change, t saturates at 15
  always_ff @(posedge clk) begin
    if (!reset || state_next != state) begin
      presc <= '0;
      t     <= '0;
      t_new <= 1'b0;
    end else if (presc == PW'(UNIT_CYCLES - 1)) begin
      presc <= '0;
      t_new <= (t != 4'd15);
      if (t != 4'd15) t <= t + 4'd1;
    end else begin
      presc <= presc + 1'b1;
      t_new <= 1'b0;
    end
  end

  // Symbol register: append on classification, clear once the char is pushed
  always_ff @(posedge clk) begin
    if (!reset || interchar_out) begin
      sym_pat <= '0;
      sym_len <= '0;
      sym_bad <= 1'b0;
    end else if (dot_out || dash_out) begin
      if (sym_len == LW'(MAX_SYMS)) begin
        sym_bad <= 1'b1;
      end else begin
        for (int i = 0; i < MAX_SYMS; i++)
          if (i == int'(sym_len)) sym_pat[i] <= dash_out;
        sym_len <= sym_len + 1'b1;
      end
    end
  end

  morse_lut #(.MAX_SYMS(MAX_SYMS)) u_lut (
    .len     (sym_len),
    .pattern (sym_pat),
    .code    (lut_code)
  );

  assign sym_code = sym_bad ? CODE_UNKNOWN : lut_code;

  // ---------------- output FIFO ----------------
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, accept;

  assign char_valid = (fifo_count != '0);
  assign full       = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop        = char_valid && char_ready;
  assign accept     = push && (!full || pop);
  assign char_code  = char_valid ? mem[rd_ptr] : 6'd0;

  // Pointers, occupancy and sticky overflow on a dropped push
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!accept && pop) fifo_count <= fifo_count - 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end

  // Storage array, no reset needed: contents are only seen while valid
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_code;
  end

endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx with short unit / debounce times.
module tb_morse_rx;
  import morse_pkg::*;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset, button, char_ready;
  logic [5:0] char_code;
  logic       char_valid, dot_out, dash_out, interchar_out, interword_out, overflow;
  logic [3:0] t;
  logic [3:0] fifo_count;

  int n_chk = 0, n_err = 0;
  int dot_n, dash_n, ic_n, iw_n;
  int ev[$];

  morse_rx #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .button(button),
    .char_code(char_code), .char_valid(char_valid), .char_ready(char_ready),
    .dot_out(dot_out), .dash_out(dash_out),
    .interchar_out(interchar_out), .interword_out(interword_out),
    .t(t), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (dot_out)       begin dot_n++;  ev.push_back(1); end
    if (dash_out)      begin dash_n++; ev.push_back(2); end
    if (interchar_out) begin ic_n++;   ev.push_back(3); end
    if (interword_out) begin iw_n++;   ev.push_back(4); end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    dot_n = 0; dash_n = 0; ic_n = 0; iw_n = 0;
    ev.delete();
  endtask

  task automatic key(input logic lvl, input int units);
    button = lvl;
    tick(units * U);
  endtask

  // One character: dots 1 unit, dashes 3 units, 1-unit inner gaps, 3-unit tail gap
  task automatic send(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      key(1'b1, (pat[i] == "-") ? 3 : 1);
      key(1'b0, (i == pat.len() - 1) ? 3 : 1);
    end
  endtask

  task automatic pop_chk(input string tag, input int exp);
    int k = 0;
    while (!char_valid && k < 100) begin tick(1); k++; end
    check({tag, "_valid"}, int'(char_valid), 1);
    check(tag, int'(char_code), exp);
    char_ready = 1'b1;
    tick(1);
    char_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(10);
  endtask

  function automatic int ev_at(input int i);
    return (i < ev.size()) ? ev[i] : -1;
  endfunction

  initial begin
    int k;
    reset = 1'b0; button = 1'b0; char_ready = 1'b0;
    clr();
    tick(3);
    // reset state
    check("rst_valid", int'(char_valid), 0);
    check("rst_code",  int'(char_code), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf",   int'(overflow), 0);
    check("rst_t",     int'(t), 0);
    check("rst_pulse", int'({dot_out, dash_out, interchar_out, interword_out}), 0);
    reset = 1'b1;
    tick(10);
    check("idle_after_rst", int'(dut.state), int'(IDLE));

    // "A": dot, dash, then char gap
    clr();
    key(1'b1, 1); key(1'b0, 1); key(1'b1, 3);
    button = 1'b0;
    tick(16);
    check("A_nev",  ev.size(), 3);
    check("A_ev0",  ev_at(0), 1);
    check("A_ev1",  ev_at(1), 2);
    check("A_ev2",  ev_at(2), 3);
    check("A_valid", int'(char_valid), 1);
    check("A_count", int'(fifo_count), 1);
    check("A_code",  int'(char_code), 0);
    check("A_t",     int'(t), 2);
    tick(12);
    check("A_iw",    iw_n, 1);
    check("A_count2", int'(fifo_count), 2);
    pop_chk("A_pop0", 0);
    pop_chk("A_pop1", 36);
    check("A_empty", int'(fifo_count), 0);

    // "SOS" + word gap
    clr();
    send("..."); send("---"); send("...");
    tick(20);
    check("SOS_ic",    ic_n, 3);
    check("SOS_iw",    iw_n, 1);
    check("SOS_count", int'(fifo_count), 4);
    check("SOS_state", int'(dut.state), int'(IDLE));
    pop_chk("SOS_0", 18);
    pop_chk("SOS_1", 14);
    pop_chk("SOS_2", 18);
    pop_chk("SOS_3", 36);

    // Six dots overflow the symbol register
    clr();
    send("......");
    tick(20);
    check("six_dots", dot_n, 6);
    check("six_count", int'(fifo_count), 2);
    pop_chk("six_code", 63);
    pop_chk("six_sp", 36);

    // Undefined 4-symbol pattern, then digit 5
    send("..--"); send(".....");
    tick(20);
    pop_chk("undef4", 63);
    pop_chk("digit5", 31);
    pop_chk("d5_sp", 36);

    // FIFO full, consumer stalled: ninth char dropped
    repeat (8) send(".");
    check("full8_ovf", int'(overflow), 0);
    send(".");
    tick(4);
    check("drop_count", int'(fifo_count), 8);
    check("drop_ovf",   int'(overflow), 1);
    do_reset();
    check("clr_count", int'(fifo_count), 0);
    check("clr_ovf",   int'(overflow), 0);

    // FIFO full with a pop in the push cycle: push accepted
    repeat (8) send(".");
    send(".");
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (interchar_out) break;
      k++;
    end
    check("ic_seen", int'(k < 60), 1);
    char_ready = 1'b1;
    @(posedge clk);
    #1 char_ready = 1'b0;
    check("pp_count", int'(fifo_count), 8);
    check("pp_ovf",   int'(overflow), 0);
    check("pp_head",  int'(char_code), 4);

    // Key held through reset: stays in LOCKOUT, no symbol on release
    button = 1'b1;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    clr();
    tick(20);
    check("lock_state", int'(dut.state), int'(LOCKOUT));
    check("lock_count", int'(fifo_count), 0);
    button = 1'b0;
    tick(30);
    check("lock_sym",  dot_n + dash_n, 0);
    check("lock_idle", int'(dut.state), int'(IDLE));

    // Reset in the middle of a character discards it
    key(1'b1, 1); key(1'b0, 1);
    button = 1'b1;
    tick(6);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    clr();
    tick(8);
    button = 1'b0;
    tick(30);
    check("mid_count", int'(fifo_count), 0);
    check("mid_valid", int'(char_valid), 0);
    check("mid_pulses", dot_n + dash_n + ic_n + iw_n, 0);

    // t saturates at 15 during a long idle
    tick(70);
    check("t_sat", int'(t), 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case something above never returns
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
